// File: rtl/mf_gate.sv
// mf_gate: registered two-operand bitwise logic gate, {a,b} selects AND/OR/XOR/NAND.
// Ports: clk, rst_n (async low), x/y operands, a/b select, in_valid -> f, out_valid
//        (+ f_comb when MF_GATE_COMB_OUT_EN is defined).
module mf_gate #(
  parameter int unsigned WIDTH     = 1,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             a,
  input  logic             b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] f,
  output logic             out_valid
`ifdef MF_GATE_COMB_OUT_EN
  ,
  output logic [WIDTH-1:0] f_comb
`endif
);

  localparam logic [WIDTH-1:0] RST_F = WIDTH'(RESET_VAL);

  logic [1:0]       sel;
  logic [WIDTH-1:0] func_d;
  logic [WIDTH-1:0] f_q, f_d;
  logic             vld_q, vld_d;

  assign sel = {a, b};

  always_comb begin
    func_d = '0;
    case (sel)
      2'b00: func_d = x & y;
      2'b01: func_d = x | y;
      2'b10: func_d = x ^ y;
      2'b11: func_d = ~(x & y);
      default: func_d = '0;
    endcase
  end

  // Idle cycles keep f so inputs (even X) never reach the register.
  always_comb begin
    f_d   = f_q;
    vld_d = in_valid;
    if (in_valid) f_d = func_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_q   <= RST_F;
      vld_q <= 1'b0;
    end else begin
      f_q   <= f_d;
      vld_q <= vld_d;
    end
  end

  assign f         = f_q;
  assign out_valid = vld_q;

`ifdef MF_GATE_COMB_OUT_EN
  assign f_comb = func_d;
`endif

endmodule

// File: tb/tb_mf_gate.sv
// tb_mf_gate: directed bench for mf_gate, WIDTH=1 and WIDTH=4 instances,
// queue scoreboard with immediate assertions.
module tb_mf_gate;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       x1 = 1'b0, y1 = 1'b0, a1 = 1'b0, b1 = 1'b0, v1 = 1'b0;
  logic [3:0] x4 = '0, y4 = '0;
  logic       a4 = 1'b0, b4 = 1'b0, v4 = 1'b0;
  logic       f1, ov1;
  logic [3:0] f4;
  logic       ov4;
`ifdef MF_GATE_COMB_OUT_EN
  logic       fc1;
  logic [3:0] fc4;
`endif

  always #5 clk = ~clk;

  mf_gate #(.WIDTH(1), .RESET_VAL(0)) u1 (
    .clk(clk), .rst_n(rst_n), .x(x1), .y(y1), .a(a1), .b(b1),
    .in_valid(v1), .f(f1), .out_valid(ov1)
`ifdef MF_GATE_COMB_OUT_EN
    , .f_comb(fc1)
`endif
  );

  // RESET_VAL 5'h13 truncates to 4'h3
  mf_gate #(.WIDTH(4), .RESET_VAL(32'h13)) u4 (
    .clk(clk), .rst_n(rst_n), .x(x4), .y(y4), .a(a4), .b(b4),
    .in_valid(v4), .f(f4), .out_valid(ov4)
`ifdef MF_GATE_COMB_OUT_EN
    , .f_comb(fc4)
`endif
  );

  // Hand-derived WIDTH=1 truth table, bit index = {x,y,a,b}
  localparam logic [15:0] TT = 16'h3EE8;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;

  logic       q1[$];
  logic [3:0] q4[$];
  logic       expv1 = 1'b0, expv4 = 1'b0;
  logic       hold1 = 1'b0;
  logic [3:0] hold4 = 4'h3;

  task automatic chk(input string tag, input logic [3:0] obs,
                     input logic [3:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] model(input logic [3:0] x, input logic [3:0] y,
                                       input logic [1:0] s);
    logic [3:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      if (s == 2'b00)      r[i] = x[i] & y[i];
      else if (s == 2'b01) r[i] = x[i] | y[i];
      else if (s == 2'b10) r[i] = x[i] ^ y[i];
      else                 r[i] = ~(x[i] & y[i]);
    end
    return r;
  endfunction

  task automatic drv1(input logic x, input logic y, input logic a,
                      input logic b, input logic v);
    logic [15:0] tt;
    logic [3:0]  idx;
    tt = TT;
    idx = {x, y, a, b};
    x1 = x; y1 = y; a1 = a; b1 = b; v1 = v;
    expv1 = v;
    if (v) q1.push_back(tt[idx]);
  endtask

  task automatic drv4(input logic [3:0] x, input logic [3:0] y, input logic a,
                      input logic b, input logic v, input logic [3:0] e);
    x4 = x; y4 = y; a4 = a; b4 = b; v4 = v;
    expv4 = v;
    if (v) q4.push_back(e);
  endtask

  task automatic tick(input string tag);
    logic [3:0] e;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      q1.delete(); q4.delete();
      expv1 = 1'b0; expv4 = 1'b0;
      hold1 = 1'b0; hold4 = 4'h3;
    end
    chk({tag, ".ov1"}, {3'b0, ov1}, {3'b0, expv1});
    if (expv1 && q1.size() > 0) begin
      hold1 = q1.pop_front();
    end
    chk({tag, ".f1"}, {3'b0, f1}, {3'b0, hold1});
    chk({tag, ".ov4"}, {3'b0, ov4}, {3'b0, expv4});
    if (expv4 && q4.size() > 0) begin
      e = q4.pop_front();
      hold4 = e;
    end
    chk({tag, ".f4"}, f4, hold4);
  endtask

  initial begin
    logic [3:0] rx, ry;
    logic [1:0] rs;
    logic [3:0] vec;

    // Reset held with a valid op presented
    drv1(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    drv4(4'hF, 4'hF, 1'b0, 1'b0, 1'b1, 4'hF);
    for (int i = 0; i < 3; i++) tick("rst_hold");

    @(negedge clk);
    rst_n = 1'b1;
    drv1(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drv4(4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0);
    tick("rel");

    // Exhaustive WIDTH=1 sweep, one vector per cycle
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      vec = 4'(i);
      drv1(vec[3], vec[2], vec[1], vec[0], 1'b1);
      tick("sweep");
    end

    // Async reset mid-cycle while f=1
    @(negedge clk);
    drv1(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    drv4(4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0);
    @(negedge clk);
    drv1(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    tick("pre_async");
    #2 rst_n = 1'b0;
    #1;
    chk("async.f1", {3'b0, f1}, 4'h0);
    chk("async.ov1", {3'b0, ov1}, 4'h0);
    chk("async.f4", f4, 4'h3);
    q1.delete();
    @(negedge clk);
    rst_n = 1'b1;
    drv1(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    hold1 = 1'b0; hold4 = 4'h3; expv4 = 1'b0;
    tick("post_async");

    // Hold: capture then idle with toggling / unknown inputs
    @(negedge clk);
    drv1(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    tick("hold_cap");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drv1(~x1, ~y1, ~a1, ~b1, 1'b0);
      if (i == 2) begin
        x1 = 1'bx; y1 = 1'bz;
        x4 = 4'bx; y4 = 4'bz;
      end
      tick("hold_idle");
    end

    // Back-to-back WIDTH=4 with hand expectations
    @(negedge clk);
    drv4(4'hA, 4'h6, 1'b1, 1'b0, 1'b1, 4'hC);
    tick("b2b_xor");
    @(negedge clk);
    drv4(4'hA, 4'h6, 1'b0, 1'b0, 1'b1, 4'h2);
    tick("b2b_and");
    @(negedge clk);
    drv4(4'hA, 4'h6, 1'b1, 1'b1, 1'b1, 4'hD);
    tick("b2b_nand");
    @(negedge clk);
    drv4(4'h3, 4'h5, 1'b0, 1'b1, 1'b1, 4'h7);
    tick("b2b_or");

    // Random WIDTH=4 traffic, occasional idle cycles
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      rx = 4'($urandom_range(15));
      ry = 4'($urandom_range(15));
      rs = 2'($urandom_range(3));
      drv4(rx, ry, rs[1], rs[0], (i % 4) != 3, model(rx, ry, rs));
      tick("rand4");
    end

    // Reset pulsed across a capturing edge discards the op
    @(negedge clk);
    drv1(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    drv4(4'hF, 4'h0, 1'b0, 1'b1, 1'b1, 4'hF);
    #2 rst_n = 1'b0;
    tick("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    drv1(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drv4(4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0);
    tick("mid_rel");
    @(negedge clk);
    drv1(1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
    drv4(4'h9, 4'hC, 1'b1, 1'b0, 1'b1, 4'h5);
    tick("mid_next");

`ifdef MF_GATE_COMB_OUT_EN
    @(negedge clk);
    drv1(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    drv4(4'hA, 4'h6, 1'b1, 1'b0, 1'b1, 4'hC);
    #1;
    chk("comb.fc1", {3'b0, fc1}, 4'h0);
    chk("comb.fc4", fc4, 4'hC);
    chk("comb.f1_old", {3'b0, f1}, {3'b0, hold1});
    tick("comb_reg");
`endif

    @(negedge clk);
    drv1(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    drv4(4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0);
    tick("drain");

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
